spi_master: RTL

//  SPI master: the initiating end of the SPI link our slave-side blocks answer. Takes one

---
 rtl/spi_master_pkg.sv | 23 ++
 rtl/spi_master_if.sv | 32 +++
 rtl/spi_master_tick_gen.sv | 35 +++
 rtl/spi_master.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and helpers for the SPI master block.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Transfer phases of the master state machine
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    // Width of the sclk edge counter, which indexes 2*data_wdt edges
    function automatic int edge_cnt_w(input int data_wdt);
        return $clog2(2 * data_wdt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_if
//  Description : Word handshake and SPI pin bundle of the SPI master.
//                master = the spi_master side, slave = the user/link side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if #(
    parameter int DATA_WDT = 8
) ();
    logic [DATA_WDT-1:0] txData;
    logic                txValid;
    logic                txReady;
    logic [DATA_WDT-1:0] rxData;
    logic                rxRdy;
    logic                busy;
    logic                ssel;
    logic                sclk;
    logic                mosi;
    logic                miso;

    modport master (
        input  txData, txValid, miso,
        output txReady, rxData, rxRdy, busy, ssel, sclk, mosi
    );

    modport slave (
        output txData, txValid, miso,
        input  txReady, rxData, rxRdy, busy, ssel, sclk, mosi
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tick_gen
//  Description : Divides clk by CLK_DIV, giving a one-cycle tick at the end of
//                every sclk half-period. Held at zero while cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    output logic      o_tick
);
    localparam int              c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    // Free-running divider, restarted whenever the master is idle
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_clr && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : SPI master, one DATA_WDT-bit word per valid/ready handshake,
//                MSB first, any CPOL/CPHA, sclk = clk / (2*CLK_DIV).
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter logic CPOL     = 1'b1,
    parameter logic CPHA     = 1'b1,
    parameter int   DATA_WDT = 8,
    parameter int   CLK_DIV  = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    spi_master_if.master bus
);
    localparam int               c_EW        = edge_cnt_w(DATA_WDT);
    localparam logic [c_EW-1:0]  c_LAST_EDGE = c_EW'(2 * DATA_WDT - 1);

    spi_state_t          r_state;
    logic [c_EW-1:0]     r_edge;
    logic [DATA_WDT-2:0] r_txsh;     // MSB is already on mosi, so only the rest is kept
    logic [DATA_WDT-1:0] r_rxsh;
    logic [DATA_WDT-1:0] r_rxdata;
    logic                r_ssel;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_ready;
    logic                r_busy;
    logic                r_rxrdy;

    logic                w_tick;
    logic                w_odd;
    logic                w_sample;
    logic                w_shift;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (r_state == IDLE),
        .o_tick (w_tick)
    );

    // Decide what the upcoming sclk edge does; r_edge holds (edge number - 1)
    always_comb begin
        w_odd    = (r_edge[0] == 1'b0);
        w_sample = 1'b0;
        w_shift  = 1'b0;
        if (CPHA == 1'b0) begin
            w_sample = w_odd;
            w_shift  = !w_odd && (r_edge != c_LAST_EDGE);
        end else begin
            w_sample = !w_odd;
            w_shift  = w_odd && (r_edge != '0);
        end
    end

    // Transfer state machine with all pin and handshake outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_edge   <= '0;
            r_txsh   <= '0;
            r_rxsh   <= '0;
            r_rxdata <= '0;
            r_ssel   <= 1'b1;
            r_sclk   <= CPOL;
            r_mosi   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_rxrdy  <= 1'b0;
        end else begin
            r_rxrdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ssel <= 1'b1;
                    r_sclk <= CPOL;
                    r_mosi <= 1'b0;
                    if (bus.txValid && r_ready) begin
                        r_txsh  <= bus.txData[DATA_WDT-2:0];
                        r_mosi  <= bus.txData[DATA_WDT-1];
                        r_rxsh  <= '0;
                        r_ssel  <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= LEAD;
                    end
                end
                LEAD: begin
                    if (w_tick) begin
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (w_sample) begin
                            r_rxsh <= {r_rxsh[DATA_WDT-2:0], bus.miso};
                        end
                        if (w_shift) begin
                            r_mosi <= r_txsh[DATA_WDT-2];
                            r_txsh <= r_txsh << 1;
                        end
                        if (r_edge == c_LAST_EDGE) begin
                            r_edge  <= '0;
                            r_state <= TRAIL;
                        end else begin
                            r_edge <= r_edge + 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (w_tick) begin
                        r_state  <= IDLE;
                        r_ssel   <= 1'b1;
                        r_mosi   <= 1'b0;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_rxrdy  <= 1'b1;
                        r_rxdata <= r_rxsh;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.txReady = r_ready;
    assign bus.busy    = r_busy;
    assign bus.rxRdy   = r_rxrdy;
    assign bus.rxData  = r_rxdata;
    assign bus.ssel    = r_ssel;
    assign bus.sclk    = r_sclk;
    assign bus.mosi    = r_mosi;

endmodule
`default_nettype wire
